// File: rtl/tm1638_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tm1638_frame_ctrl
// Description : TM1638 LED&KEY refresh engine. Each accepted update sends a
//               write command, address + 16 display bytes and the display
//               control byte, optionally followed by a 4-byte key scan.
// Revision    : 1.0 - initial release
// ============================================================================
module tm1638_frame_ctrl #(
  parameter int CLK_DIV    = 25,
  parameter int NUM_DIGITS = 8,
  parameter int READ_KEYS  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*NUM_DIGITS-1:0] seg_data_i,
  input  logic [NUM_DIGITS-1:0]   led_data_i,
  input  logic [2:0]              brightness_i,
  input  logic                    disp_on_i,
  input  logic                    upd_valid_i,
  output logic                    upd_ready_o,
  output logic                    busy_o,
  output logic                    stb_o,
  output logic                    sclk_o,
  output logic                    dio_out_o,
  output logic                    dio_oe_o,
  input  logic                    dio_in_i,
  output logic [31:0]             keys_o,
  output logic                    keys_valid_o
);

  localparam int            CW       = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CTRL = 3'd3;
  localparam logic [2:0] S_KEY  = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [CW-1:0]           div_q, div_d;
  logic [8:0]              tick_q, tick_d;   // tick index inside the current frame
  logic [8*NUM_DIGITS-1:0] seg_q;
  logic [NUM_DIGITS-1:0]   led_q;
  logic [2:0]              bright_q;
  logic                    on_q;
  logic                    stb_q, stb_d, sclk_q, sclk_d, dio_q, dio_d, oe_q, oe_d;
  logic [31:0]             shift_q, shift_d, keys_q, keys_d;
  logic                    kv_q, kv_d;

  logic         accept, tick, frame_done, is_key, bit_val;
  logic [8:0]   last_idx, wr_end, hold_idx;
  logic [7:0]   bit_idx;
  logic [127:0] data_bytes;
  logic [135:0] frame_vec;

  assign accept     = (state_q == S_IDLE) && upd_valid_i;
  assign tick       = (state_q != S_IDLE) && (div_q == DIV_LAST);
  assign frame_done = tick && (tick_q == last_idx);
  assign is_key     = (state_q == S_KEY);
  assign hold_idx   = last_idx - 9'd2;
  // On odd (data) ticks t = 2k+1, t>>1 is the serial bit number k.
  assign bit_idx    = tick_q[8:1];
  assign bit_val    = frame_vec[bit_idx];

  // Display RAM image: even address = segments, odd address = LED in bit0.
  for (genvar d = 0; d < 8; d++) begin : g_digit
    if (d < NUM_DIGITS) begin : g_used
      assign data_bytes[16*d +: 8]   = seg_q[8*d +: 8];
      assign data_bytes[16*d+8 +: 8] = {7'd0, led_q[d]};
    end else begin : g_unused
      assign data_bytes[16*d +: 16] = 16'd0;
    end
  end

  // Per-frame byte stream and length, selected by the current frame
  always_comb begin
    last_idx  = 9'd19;
    wr_end    = 9'd16;
    frame_vec = {128'd0, 8'h40};
    case (state_q)
      S_DATA: begin
        last_idx  = 9'd275;
        wr_end    = 9'd272;
        frame_vec = {data_bytes, 8'hC0};
      end
      S_CTRL:  frame_vec = {128'd0, 4'h8, on_q, bright_q};
      S_KEY: begin
        last_idx  = 9'd85;
        frame_vec = {128'd0, 8'h42};
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: frames advance on their final gap tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CMD;
      S_CMD:   if (frame_done) state_d = S_DATA;
      S_DATA:  if (frame_done) state_d = S_CTRL;
      S_CTRL:  if (frame_done) state_d = (READ_KEYS != 0) ? S_KEY : S_IDLE;
      S_KEY:   if (frame_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: pin levels, divider, tick index and key capture for the next cycle
  always_comb begin
    stb_d   = stb_q;
    sclk_d  = sclk_q;
    dio_d   = dio_q;
    oe_d    = oe_q;
    shift_d = shift_q;
    keys_d  = keys_q;
    kv_d    = 1'b0;
    div_d   = (state_q == S_IDLE || div_q == DIV_LAST) ? '0 : div_q + CW'(1);
    tick_d  = tick_q;
    if (tick) begin
      tick_d = frame_done ? 9'd0 : tick_q + 9'd1;
      if (tick_q == 9'd0) begin
        stb_d  = 1'b0;
        sclk_d = 1'b1;
      end else if (tick_q <= wr_end) begin
        sclk_d = ~tick_q[0];
        oe_d   = 1'b1;
        if (tick_q[0]) dio_d = bit_val;
      end else if (is_key && tick_q <= 9'd18) begin
        sclk_d = 1'b1;
        oe_d   = 1'b0;
        dio_d  = 1'b1;
      end else if (is_key && tick_q <= 9'd82) begin
        sclk_d = ~tick_q[0];
        oe_d   = 1'b0;
        // Key bits are taken on the edge that raises sclk.
        if (!tick_q[0]) shift_d = {dio_in_i, shift_q[31:1]};
      end else if (tick_q == hold_idx) begin
        stb_d  = 1'b0;
        sclk_d = 1'b1;
        dio_d  = 1'b1;
        oe_d   = 1'b1;
      end else begin
        stb_d  = 1'b1;
        sclk_d = 1'b1;
        dio_d  = 1'b1;
        oe_d   = 1'b1;
      end
      if (frame_done && is_key) begin
        keys_d = shift_q;
        kv_d   = 1'b1;
      end
    end
  end

  // Datapath registers and request shadow copies
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      tick_q   <= '0;
      seg_q    <= '0;
      led_q    <= '0;
      bright_q <= '0;
      on_q     <= 1'b0;
      stb_q    <= 1'b1;
      sclk_q   <= 1'b1;
      dio_q    <= 1'b1;
      oe_q     <= 1'b1;
      shift_q  <= '0;
      keys_q   <= '0;
      kv_q     <= 1'b0;
    end else begin
      div_q   <= div_d;
      tick_q  <= tick_d;
      if (accept) begin
        seg_q    <= seg_data_i;
        led_q    <= led_data_i;
        bright_q <= brightness_i;
        on_q     <= disp_on_i;
      end
      stb_q   <= stb_d;
      sclk_q  <= sclk_d;
      dio_q   <= dio_d;
      oe_q    <= oe_d;
      shift_q <= shift_d;
      keys_q  <= keys_d;
      kv_q    <= kv_d;
    end
  end

  assign upd_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign stb_o        = stb_q;
  assign sclk_o       = sclk_q;
  assign dio_out_o    = dio_q;
  assign dio_oe_o     = oe_q;
  assign keys_o       = keys_q;
  assign keys_valid_o = kv_q;

endmodule
`default_nettype wire

// File: tb/tb_tm1638_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tm1638_frame_ctrl
// Description : Bench for tm1638_frame_ctrl. Instance A: CLK_DIV=2, 8 digits,
//               write only. Instance B: CLK_DIV=3, 4 digits, key scan.
//               A pin-level decoder rebuilds the byte stream of every STB
//               frame and a key-matrix model answers the read phase.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_tm1638_frame_ctrl;

  localparam int DIV_A = 2;
  localparam int DIV_B = 3;
  localparam int MAXF  = 64;

  logic        clk    = 1'b0;
  logic        rst    = 1'b0;
  logic [63:0] seg    = '0;
  logic [7:0]  led    = '0;
  logic [2:0]  bright = '0;
  logic        disp   = 1'b0;
  logic [1:0]  valid  = '0;
  logic [1:0]  dio_in = 2'b11;
  wire  [1:0]  ready, busy, stb, sclk, dout, oe, kv;
  wire  [31:0] keys_a, keys_b;

  always #5 clk = ~clk;

  tm1638_frame_ctrl #(.CLK_DIV(DIV_A), .NUM_DIGITS(8), .READ_KEYS(0)) u_a (
    .clk(clk), .rst(rst), .seg_data_i(seg), .led_data_i(led),
    .brightness_i(bright), .disp_on_i(disp), .upd_valid_i(valid[0]),
    .upd_ready_o(ready[0]), .busy_o(busy[0]), .stb_o(stb[0]), .sclk_o(sclk[0]),
    .dio_out_o(dout[0]), .dio_oe_o(oe[0]), .dio_in_i(dio_in[0]),
    .keys_o(keys_a), .keys_valid_o(kv[0]));

  tm1638_frame_ctrl #(.CLK_DIV(DIV_B), .NUM_DIGITS(4), .READ_KEYS(1)) u_b (
    .clk(clk), .rst(rst), .seg_data_i(seg[31:0]), .led_data_i(led[3:0]),
    .brightness_i(bright), .disp_on_i(disp), .upd_valid_i(valid[1]),
    .upd_ready_o(ready[1]), .busy_o(busy[1]), .stb_o(stb[1]), .sclk_o(sclk[1]),
    .dio_out_o(dout[1]), .dio_oe_o(oe[1]), .dio_in_i(dio_in[1]),
    .keys_o(keys_b), .keys_valid_o(kv[1]));

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- pin decoder and key model ----------------
  logic [167:0] dec_bits [2][MAXF];
  int           dec_n    [2][MAXF];
  int           dec_nfr  [2] = '{0, 0};
  int           kv_cnt   [2] = '{0, 0};
  int           oe0_cnt  [2] = '{0, 0};
  logic [167:0] cur      [2];
  int           ncur     [2] = '{0, 0};
  logic [1:0]   pstb  = 2'b11;
  logic [1:0]   psclk = 2'b11;
  logic [31:0]  kpat  = '0;
  int           rbit  = 0;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (kv[i]) kv_cnt[i]++;
      if (!oe[i]) oe0_cnt[i]++;
      if (pstb[i] && !stb[i]) begin
        ncur[i] = 0;
        cur[i]  = '0;
        if (i == 1) rbit = 0;
      end
      if (!stb[i] && !psclk[i] && sclk[i] && ncur[i] < 168) begin
        cur[i][ncur[i]] = oe[i] ? dout[i] : dio_in[i];
        ncur[i]++;
      end
      if (!pstb[i] && stb[i] && dec_nfr[i] < MAXF) begin
        dec_bits[i][dec_nfr[i]] = cur[i];
        dec_n[i][dec_nfr[i]]    = ncur[i];
        dec_nfr[i]++;
      end
      if (i == 1 && psclk[1] && !sclk[1] && !oe[1] && rbit < 32) begin
        dio_in[1] = kpat[rbit];
        rbit++;
      end
      pstb[i]  = stb[i];
      psclk[i] = sclk[i];
    end
  end

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [167:0] act, input logic [167:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: the byte sequence each frame must carry, from the protocol rules.
  logic [167:0] exp_bits [4];
  int           exp_n    [4];
  int           exp_nfr;

  function automatic void build_expected(input int i, input logic [63:0] s, input logic [7:0] l,
                                         input logic [2:0] br, input logic o, input logic [31:0] kp);
    int         nd;
    logic [7:0] b;
    nd = (i == 0) ? 8 : 4;
    exp_bits[0] = 168'h40;
    exp_n[0]    = 8;
    exp_bits[1] = 168'hC0;
    exp_n[1]    = 8 * 17;
    for (int a = 0; a < 16; a++) begin
      int d;
      d = a / 2;
      if (d >= nd)         b = 8'h00;
      else if (a % 2 == 0) b = s[8*d +: 8];
      else                 b = {7'd0, l[d]};
      exp_bits[1][8*(a+1) +: 8] = b;
    end
    exp_bits[2] = 168'(8'h80 | (8'(o) << 3) | 8'(br));
    exp_n[2]    = 8;
    exp_bits[3] = {128'd0, kp, 8'h42};
    exp_n[3]    = 40;
    exp_nfr     = (i == 1) ? 4 : 3;
  endfunction

  task automatic check_frames(input int i, input int base, input string tag);
    for (int f = 0; f < exp_nfr; f++) begin
      if (base + f < MAXF) begin
        check($sformatf("%s inst%0d frame%0d length", tag, i, f),
              168'(dec_n[i][base+f]), 168'(exp_n[f]));
        check($sformatf("%s inst%0d frame%0d bytes", tag, i, f),
              dec_bits[i][base+f], exp_bits[f]);
      end
    end
  endtask

  // One refresh on both instances, checked end to end.
  task automatic run_txn(input logic [63:0] s, input logic [7:0] l, input logic [2:0] br,
                         input logic o, input logic [31:0] kp, input string tag,
                         output int base_a);
    int         base [2];
    int         kv0  [2];
    int         oe0  [2];
    longint     lat  [2];
    longint     acc;
    logic [1:0] done;
    seg = s; led = l; bright = br; disp = o; kpat = kp;
    for (int i = 0; i < 2; i++) begin
      base[i] = dec_nfr[i]; kv0[i] = kv_cnt[i]; oe0[i] = oe0_cnt[i]; lat[i] = 0;
    end
    base_a = base[0];
    valid = 2'b11;
    @(negedge clk);
    acc   = cyc;
    valid = 2'b00;
    check({tag, " ready/busy after accept"}, 168'({ready, busy}), 168'(4'b0011));
    // Inputs wander while the frame is in flight.
    seg = {$urandom, $urandom}; led = 8'($urandom); bright = 3'($urandom); disp = ~o;
    done = 2'b00;
    for (int c = 0; c < 3000 && done != 2'b11; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        if (!done[i] && ready[i]) begin done[i] = 1'b1; lat[i] = cyc - acc; end
    end
    repeat (2) @(negedge clk);
    check({tag, " latency A"}, 168'(lat[0]), 168'(316 * DIV_A));
    check({tag, " latency B"}, 168'(lat[1]), 168'(402 * DIV_B));
    for (int i = 0; i < 2; i++) begin
      build_expected(i, s, l, br, o, kp);
      check($sformatf("%s inst%0d frame count", tag, i), 168'(dec_nfr[i] - base[i]), 168'(exp_nfr));
      check_frames(i, base[i], tag);
    end
    check({tag, " keys_valid pulses A"}, 168'(kv_cnt[0] - kv0[0]), 168'(0));
    check({tag, " keys_valid pulses B"}, 168'(kv_cnt[1] - kv0[1]), 168'(1));
    check({tag, " keys B"}, 168'(keys_b), 168'(kp));
    check({tag, " keys A"}, 168'(keys_a), 168'(0));
    check({tag, " dio_oe low cycles A"}, 168'(oe0_cnt[0] - oe0[0]), 168'(0));
    check({tag, " dio_oe low cycles B"}, 168'(oe0_cnt[1] - oe0[1]), 168'(66 * DIV_B));
  endtask

  typedef struct {
    logic [63:0] seg;
    logic [7:0]  led;
    logic [2:0]  br;
    logic        on;
    logic [31:0] kp;
    logic [7:0]  exp_ctrl;
    logic [31:0] exp_keys;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int           b;
    int           b0;
    longint       acc;
    longint       lat0;
    logic [167:0] fr;

    tbl[0] = '{64'h3F,                  8'h01, 3'd7, 1'b1, 32'h815A00A5, 8'h8F, 32'h815A00A5};
    tbl[1] = '{64'h7F6F07075B4F666D,    8'hA5, 3'd0, 1'b0, 32'h00000000, 8'h80, 32'h00000000};
    tbl[2] = '{64'hFFFFFFFFFFFFFFFF,    8'hFF, 3'd3, 1'b1, 32'hFFFFFFFF, 8'h8B, 32'hFFFFFFFF};
    tbl[3] = '{64'h0102030405060708,    8'h80, 3'd5, 1'b0, 32'h12345678, 8'h85, 32'h12345678};

    // Reset held while inputs toggle: pins stay at idle levels.
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      seg = {$urandom, $urandom}; led = 8'($urandom); bright = 3'($urandom);
      disp = 1'($urandom); valid = 2'($urandom);
      @(negedge clk);
      check("reset hold pins", 168'({stb, sclk, dout, oe, ready, busy, kv, keys_a, keys_b}),
            168'({10'h3FF, 4'h0, 64'd0}));
    end
    valid = 2'b00;
    rst   = 1'b1;
    @(negedge clk);

    // Table vectors.
    for (int t = 0; t < 4; t++) begin
      run_txn(tbl[t].seg, tbl[t].led, tbl[t].br, tbl[t].on, tbl[t].kp, $sformatf("tbl%0d", t), b);
      fr = dec_bits[0][b+2];
      check($sformatf("tbl%0d ctrl byte", t), 168'(fr[7:0]), 168'(tbl[t].exp_ctrl));
      check($sformatf("tbl%0d keys", t), 168'(keys_b), 168'(tbl[t].exp_keys));
    end

    // Random refreshes against the reference.
    for (int r = 0; r < 4; r++)
      run_txn({$urandom, $urandom}, 8'($urandom), 3'($urandom), 1'($urandom), $urandom,
              $sformatf("rnd%0d", r), b);

    // Request held high on A; inputs changed mid-DATA; re-accept on the idle cycle.
    b0 = dec_nfr[0];
    seg = 64'h1122334455667788; led = 8'h5A; bright = 3'd2; disp = 1'b1;
    valid = 2'b01;
    @(negedge clk);
    acc = cyc;
    repeat (100) @(negedge clk);
    seg = 64'h99AABBCCDDEEFF00; led = 8'hC3; bright = 3'd6; disp = 1'b0;
    lat0 = 0;
    for (int c = 0; c < 1000 && lat0 == 0; c++) begin
      @(negedge clk);
      if (ready[0]) lat0 = cyc - acc;
    end
    check("held first latency", 168'(lat0), 168'(316 * DIV_A));
    @(negedge clk);
    check("held re-accept", 168'(ready[0]), 168'(0));
    valid = 2'b00;
    lat0 = 0;
    for (int c = 0; c < 1000 && lat0 == 0; c++) begin
      @(negedge clk);
      if (ready[0]) lat0 = 1;
    end
    repeat (2) @(negedge clk);
    check("held frame count", 168'(dec_nfr[0] - b0), 168'(6));
    build_expected(0, 64'h1122334455667788, 8'h5A, 3'd2, 1'b1, 32'd0);
    check_frames(0, b0, "held1");
    build_expected(0, 64'h99AABBCCDDEEFF00, 8'hC3, 3'd6, 1'b0, 32'd0);
    check_frames(0, b0 + 3, "held2");

    // Asynchronous reset during DATA byte 5 of A, then a clean refresh.
    seg = {$urandom, $urandom}; kpat = $urandom;
    valid = 2'b11;
    @(negedge clk);
    valid = 2'b00;
    repeat (209) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid-frame reset pins", 168'({stb, sclk, dout, oe, ready, busy, kv, keys_b}),
          168'({10'h3FF, 4'h0, 32'd0}));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_txn(64'hA1B2C3D4E5F60718, 8'h3C, 3'd4, 1'b1, 32'hC0FFEE11, "post-reset", b);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
